// File: rtl/rr_mux8_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux8_arbiter
//
// Round-robin arbiter and sequencer for one shared 8:1 bit-mux channel.
// Eight requesters compete for the channel and one winner holds it at a time.
// Each tenure is capped at MAX_BURST cycles so nobody starves the others.
// The selected data bit comes back registered, one cycle behind the grant.
//
// Ports:
//   clk_in       in   1  clock, all state changes on the rising edge
//   rst_in       in   1  synchronous active-high reset
//   req_in       in   8  request vector, bit i = requester i wants the channel
//   data_in      in   8  mux data inputs, bit i belongs to requester i
//   gnt_out      out  8  registered one-hot grant, zero when idle
//   sel_out      out  3  registered mux select (index of the granted requester)
//   valid_out    out  1  high while a grant is active
//   y_out        out  1  registered data_in[sel_out]
//   y_valid_out  out  1  qualifies y_out, valid_out delayed one cycle
// ---------------------------------------------------------------------------
module rr_mux8_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] req_in,
  input  logic [7:0] data_in,
  output logic [7:0] gnt_out,
  output logic [2:0] sel_out,
  output logic       valid_out,
  output logic       y_out,
  output logic       y_valid_out
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  state_t           state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic [2:0]       pick_start;
  logic [2:0]       pick_idx;
  logic             pick_found;
  logic             hold;

  // Scan req starting at 'start' and wrapping mod 8. Walking the offsets from
  // the far end down to zero means the last hit written is the nearest one,
  // so the lowest offset from 'start' wins.
  function automatic logic [3:0] pick(input logic [7:0] req, input logic [2:0] start);
    logic [2:0] idx;
    logic [3:0] result;
    result = {1'b0, start};
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (req[idx]) begin
        result = {1'b1, idx};
      end
    end
    return result;
  endfunction

  // Work out who would win this cycle. In IDLE the scan starts at the saved
  // pointer. During a grant it starts just past the current holder, which puts
  // the holder last in line when its tenure ends.
  always_comb begin
    pick_start = (state == GRANT) ? (sel_out + 3'd1) : ptr;
    {pick_found, pick_idx} = pick(req_in, pick_start);
    hold = (state == GRANT) && req_in[sel_out] && (cnt < MAX_CNT);
  end

  // Main sequencer. The registered data bit is computed from the grant that
  // was active before this edge, so y_out trails the grant by one cycle.
  // On release the next winner is granted on the same edge, with no idle
  // bubble between tenures.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      cnt         <= '0;
      gnt_out     <= 8'd0;
      sel_out     <= 3'd0;
      valid_out   <= 1'b0;
      y_out       <= 1'b0;
      y_valid_out <= 1'b0;
    end else begin
      y_out       <= valid_out ? data_in[sel_out] : 1'b0;
      y_valid_out <= valid_out;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= GRANT;
            sel_out   <= pick_idx;
            gnt_out   <= 8'd1 << pick_idx;
            valid_out <= 1'b1;
            cnt       <= CNT_W'(1);
          end
        end
        GRANT: begin
          if (hold) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            ptr <= sel_out + 3'd1;
            if (pick_found) begin
              sel_out   <= pick_idx;
              gnt_out   <= 8'd1 << pick_idx;
              valid_out <= 1'b1;
              cnt       <= CNT_W'(1);
            end else begin
              state     <= IDLE;
              sel_out   <= 3'd0;
              gnt_out   <= 8'd0;
              valid_out <= 1'b0;
              cnt       <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
